// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one bit per cycle, valid/ready handshakes.
// Optional leading-zero blanking mask is enabled by defining BIN2BCD_SEQ_BLANK_EN.
module bin2bcd_seq #(
    parameter int WIDTH_BIN = 18,
    parameter int WIDTH_BCD = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_BIN-1:0]   in_bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_BCD-1:0]   out_bcd,
    output logic                   out_ovf,
    output logic [WIDTH_BCD/4-1:0] out_blank,
    output logic                   busy
);
    localparam int ND = WIDTH_BCD / 4;
    localparam int CW = $clog2(WIDTH_BIN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH_BIN-1:0] bin;
    logic [WIDTH_BCD-1:0] bcd, adj, bcd_n;
    logic                 ovf, ovf_n, last;
    logic [CW-1:0]        cnt;

    assign in_ready  = state == IDLE;
    assign busy      = state == SHIFT;
    assign out_valid = state == DONE;
    assign last      = cnt == CW'(WIDTH_BIN - 1);

    always_comb begin
        adj = bcd;
        for (int i = 0; i < ND; i++)
            adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end

    // The bit falling off the top digit means the operand does not fit in ND digits.
    assign bcd_n = {adj[WIDTH_BCD-2:0], bin[WIDTH_BIN-1]};
    assign ovf_n = ovf | adj[WIDTH_BCD-1];

    always_comb begin
        state_n = state;
        if (state == IDLE && in_valid)
            state_n = SHIFT;
        else if (state == SHIFT && last)
            state_n = DONE;
        else if (state == DONE && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;

    // out_bcd/out_ovf are captured on the final iteration so they hold the last result outside DONE.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bin     <= '0;
            bcd     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            out_bcd <= '0;
            out_ovf <= 1'b0;
        end else if (in_ready && in_valid) begin
            bin <= in_bin;
            bcd <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (busy) begin
            bin <= bin << 1;
            bcd <= bcd_n;
            ovf <= ovf_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                out_bcd <= bcd_n;
                out_ovf <= ovf_n;
            end
        end

`ifdef BIN2BCD_SEQ_BLANK_EN
    logic [ND-1:0] blank_n;
    logic          all_zero;

    always_comb begin
        blank_n  = '0;
        all_zero = 1'b1;
        for (int i = ND - 1; i >= 1; i--) begin
            all_zero   = all_zero && bcd_n[4*i+:4] == 4'd0;
            blank_n[i] = all_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            out_blank <= '0;
        else if (busy && last)
            out_blank <= blank_n;
`else
    assign out_blank = '0;
`endif
endmodule
